pack_data_axis: RTL and testbench

//  Receive-side packer after lane deskew/descramble. Gathers per-cycle lane bytes (x1..xMAX_NUM_LANES, 8/16/32-bit PIPE)

---
 rtl/pack_data_axis_if.sv | 21 ++
 rtl/pack_data_axis.sv | 219 +++++++++++++++++++++
 tb/tb_pack_data_axis.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pack_data_axis_if.sv
`default_nettype none
// ============================================================================
// Module   : pack_data_axis_if
// Brief    : AXI-Stream beat bundle (tdata/tkeep/tvalid/tready/tlast/tuser)
//            carried from the packer to its sink.
// Revision : 1.0
// ============================================================================
interface pack_data_axis_if #(
    parameter int OUT_WIDTH = 512
);
    logic [OUT_WIDTH-1:0]   tdata;
    logic [OUT_WIDTH/8-1:0] tkeep;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic                   tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/pack_data_axis.sv
`default_nettype none
// ============================================================================
// Module   : pack_data_axis
// Brief    : Packs striped PIPE lane bytes into AXI-Stream beats with framing,
//            lane reversal, output FIFO and EDB/link-down abort.
//            Define PACK_DATA_AXIS_STATS_EN for packet/drop counters.
// Revision : 1.0
// ============================================================================
module pack_data_axis #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_NUM_LANES = 4,
    parameter int OUT_WIDTH     = 512,
    parameter int FIFO_DEPTH    = 4
) (
    input  wire                                  clk_i,
    input  wire                                  rst_i,
    input  wire                                  phy_link_up_i,
    input  wire                                  lane_reverse_i,
    input  wire  [5:0]                           pipe_width_i,
    input  wire  [5:0]                           num_active_lanes_i,
    input  wire  [MAX_NUM_LANES*DATA_WIDTH-1:0]  data_i,
    input  wire  [MAX_NUM_LANES-1:0]             data_valid_i,
    input  wire  [4*MAX_NUM_LANES-1:0]           data_k_i,
    pack_data_axis_if.master                     m_axis,
    output logic                                 overflow_o
`ifdef PACK_DATA_AXIS_STATS_EN
    ,
    output logic [31:0]                          pkt_count_o,
    output logic [15:0]                          drop_count_o
`endif
);
    localparam int c_BPL       = DATA_WIDTH / 8;
    localparam int c_IN_BYTES  = MAX_NUM_LANES * c_BPL;
    localparam int c_OUT_BYTES = OUT_WIDTH / 8;
    localparam int c_CNT_W     = $clog2(c_OUT_BYTES) + 1;
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int c_ENT_W     = OUT_WIDTH + c_OUT_BYTES + 2;

    localparam logic [7:0] c_SYM_STP = 8'hFB;
    localparam logic [7:0] c_SYM_SDP = 8'h5C;
    localparam logic [7:0] c_SYM_END = 8'hFD;
    localparam logic [7:0] c_SYM_EDB = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [OUT_WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]     r_off;
    logic                   r_overflow;
    logic [c_ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]       r_wr_ptr;
    logic [c_PTR_W:0]       r_rd_ptr;

    int                     w_lanes, w_bpl, w_nb, w_keep_n, w_base, w_sum, w_push_cnt;
    logic [7:0]             w_byte  [c_IN_BYTES];
    logic                   w_kflag [c_IN_BYTES];
    logic                   w_valid, w_start, w_take, w_term, w_edb, w_full;
    logic [OUT_WIDTH-1:0]   w_acc_nxt, w_push_data;
    logic [c_OUT_BYTES-1:0] w_push_keep;
    logic                   w_push, w_push_last, w_push_user;
    logic                   w_empty, w_fifo_full, w_pop, w_accept, w_wr_en, w_drop;
    logic [c_ENT_W-1:0]     w_head;

    assign w_lanes = int'(num_active_lanes_i);
    assign w_bpl   = int'(pipe_width_i >> 3);
    assign w_nb    = (w_lanes * w_bpl > c_IN_BYTES) ? c_IN_BYTES : w_lanes * w_bpl;
    assign w_valid = |data_valid_i;

    // Stream byte t*N+l is symbol t of logical lane l (PCIe byte striping).
    always_comb begin
        for (int i = 0; i < c_IN_BYTES; i++) begin
            w_byte[i]  = 8'h00;
            w_kflag[i] = 1'b0;
        end
        for (int t = 0; t < c_BPL; t++) begin
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
                if (l < w_lanes && t < w_bpl) begin
                    w_byte[t*w_lanes + l] =
                        data_i[(lane_reverse_i ? (w_lanes - 1 - l) : l)*DATA_WIDTH + t*8 +: 8];
                    w_kflag[t*w_lanes + l] =
                        data_k_i[(lane_reverse_i ? (w_lanes - 1 - l) : l)*c_BPL + t];
                end
            end
        end
    end

    assign w_start = w_valid && phy_link_up_i && w_kflag[0] &&
                     (w_byte[0] == c_SYM_STP || w_byte[0] == c_SYM_SDP);
    assign w_take  = (r_state == ST_IDLE  && w_start) ||
                     (r_state == ST_ACCUM && phy_link_up_i && w_valid);

    // Scan downwards so the earliest terminator in the cycle wins.
    always_comb begin
        w_term   = 1'b0;
        w_edb    = 1'b0;
        w_keep_n = w_nb;
        for (int i = c_IN_BYTES - 1; i >= 0; i--) begin
            if (i < w_nb && w_kflag[i] &&
                (w_byte[i] == c_SYM_END || w_byte[i] == c_SYM_EDB)) begin
                w_term   = 1'b1;
                w_edb    = (w_byte[i] == c_SYM_EDB);
                w_keep_n = i + 1;
            end
        end
    end

    always_comb begin
        w_base    = (r_state == ST_ACCUM) ? int'(r_off) : 0;
        w_sum     = w_base + w_keep_n;
        w_full    = (w_sum >= c_OUT_BYTES);
        w_acc_nxt = (w_base == 0) ? '0 : r_acc;
        for (int j = 0; j < c_OUT_BYTES; j++) begin
            if (j >= w_base && j < w_sum) begin
                w_acc_nxt[j*8 +: 8] = w_byte[j - w_base];
            end
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_push_user = 1'b0;
        w_push_data = w_acc_nxt;
        w_push_cnt  = w_sum;
        if (r_state == ST_ACCUM && !phy_link_up_i) begin
            w_push      = 1'b1;
            w_push_last = 1'b1;
            w_push_user = 1'b1;
            w_push_data = r_acc;
            w_push_cnt  = int'(r_off);
        end else if (w_take) begin
            w_push      = w_full || w_term;
            w_push_last = w_term;
            w_push_user = w_term && w_edb;
        end
        for (int j = 0; j < c_OUT_BYTES; j++) begin
            w_push_keep[j] = (j < w_push_cnt);
        end
    end

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                         (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_pop       = !w_empty && m_axis.tready;
    assign w_accept    = !w_fifo_full || w_pop;
    assign w_wr_en     = w_push && w_accept;
    assign w_drop      = w_push && !w_accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_off      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_take) begin
                r_acc <= w_acc_nxt;
                r_off <= (w_full || w_term) ? '0 : c_CNT_W'(w_sum);
                if (w_term) begin
                    r_state <= ST_IDLE;
                end else if (w_drop) begin
                    r_state <= ST_DROP;
                end else begin
                    r_state <= ST_ACCUM;
                end
            end else if (r_state == ST_ACCUM && !phy_link_up_i) begin
                r_state <= ST_IDLE;
                r_off   <= '0;
            end else if (r_state == ST_DROP && (!phy_link_up_i || (w_valid && w_term))) begin
                r_state <= ST_IDLE;
            end else if (r_state != ST_IDLE && r_state != ST_ACCUM && r_state != ST_DROP) begin
                r_state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {w_push_user, w_push_last, w_push_keep, w_push_data};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Gate with tvalid so the unreset storage never shows on the bus.
    assign w_head        = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_empty ? '0 : w_head[OUT_WIDTH-1:0];
    assign m_axis.tkeep  = w_empty ? '0 : w_head[OUT_WIDTH +: c_OUT_BYTES];
    assign m_axis.tlast  = !w_empty && w_head[c_ENT_W-2];
    assign m_axis.tuser  = !w_empty && w_head[c_ENT_W-1];
    assign overflow_o    = r_overflow;

`ifdef PACK_DATA_AXIS_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (w_wr_en && w_push_last) pkt_count_o <= pkt_count_o + 32'd1;
            if (w_drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_pack_data_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_pack_data_axis
// Brief    : Directed scoreboard bench for pack_data_axis (default build).
// Revision : 1.0
// ============================================================================
module tb_pack_data_axis;
    localparam int c_OUT_BYTES = 64;

    typedef struct packed {
        logic         u;
        logic         l;
        logic [63:0]  k;
        logic [511:0] d;
    } beat_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         link_up = 1'b1;
    logic         cfg_rev = 1'b0;
    logic [5:0]   cfg_width = 6'd8;
    logic [5:0]   cfg_lanes = 6'd4;
    logic [127:0] data = '0;
    logic [3:0]   data_valid = '0;
    logic [15:0]  data_k = '0;
    logic         overflow;

    int    n_checks = 0;
    int    n_fail = 0;
    int    ovf_cycles = 0;
    beat_t sb[$];
    logic [7:0] pb[$];
    bit         pk[$];

    logic         hold_v = 1'b0;
    logic [511:0] hold_d;
    logic [63:0]  hold_k;
    logic         hold_l, hold_u;

    pack_data_axis_if #(.OUT_WIDTH(512)) axis_if ();

    pack_data_axis #(
        .DATA_WIDTH(32), .MAX_NUM_LANES(4), .OUT_WIDTH(512), .FIFO_DEPTH(4)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .phy_link_up_i      (link_up),
        .lane_reverse_i     (cfg_rev),
        .pipe_width_i       (cfg_width),
        .num_active_lanes_i (cfg_lanes),
        .data_i             (data),
        .data_valid_i       (data_valid),
        .data_k_i           (data_k),
        .m_axis             (axis_if),
        .overflow_o         (overflow)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet: start symbol (K), filler bytes, optional end symbol (K).
    // Byte 5 is a non-K 0xFD so framing must be qualified by the K flag.
    task automatic build_pkt(input int n, input logic [7:0] s, input logic [7:0] e, input int seed);
        logic [7:0] v;
        bit         kf;
        pb.delete();
        pk.delete();
        for (int i = 0; i < n; i++) begin
            v  = 8'(i * 13 + seed);
            kf = 1'b0;
            if (i == 0) begin
                v  = s;
                kf = 1'b1;
            end else if (i == n - 1 && e != 8'h00) begin
                v  = e;
                kf = 1'b1;
            end else if (i == 5) begin
                v = 8'hFD;
            end
            pb.push_back(v);
            pk.push_back(kf);
        end
    endtask

    task automatic expect_pkt(input bit user);
        int    n;
        int    pos;
        int    cnt;
        beat_t b;
        n   = pb.size();
        pos = 0;
        while (pos < n) begin
            cnt = (n - pos > c_OUT_BYTES) ? c_OUT_BYTES : n - pos;
            b   = '0;
            for (int i = 0; i < cnt; i++) begin
                b.d[i*8 +: 8] = pb[pos + i];
                b.k[i]        = 1'b1;
            end
            pos += cnt;
            b.l = (pos == n);
            b.u = user && (pos == n);
            sb.push_back(b);
        end
    endtask

    task automatic drive_stream();
        int nl, bpl, b, ncyc, k, p;
        nl   = int'(cfg_lanes);
        bpl  = int'(cfg_width) / 8;
        b    = nl * bpl;
        ncyc = (pb.size() + b - 1) / b;
        for (int c = 0; c < ncyc; c++) begin
            data   = '0;
            data_k = '0;
            for (int t = 0; t < bpl; t++) begin
                for (int l = 0; l < nl; l++) begin
                    k = c * b + t * nl + l;
                    p = cfg_rev ? nl - 1 - l : l;
                    if (k < pb.size()) begin
                        data[p*32 + t*8 +: 8] = pb[k];
                        data_k[p*4 + t]       = pk[k];
                    end
                end
            end
            data_valid = 4'((1 << nl) - 1);
            @(posedge clk_i);
            #1;
        end
        data_valid = '0;
        data       = '0;
        data_k     = '0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge clk_i) begin
        beat_t        e;
        logic [511:0] mask;
        if (!rst_i) begin
            if (overflow) ovf_cycles++;
            if (hold_v && axis_if.tvalid) begin
                chk("hold_tdata", axis_if.tdata, hold_d);
                chk("hold_tkeep", axis_if.tkeep, hold_k);
                chk("hold_tlast_tuser", {axis_if.tlast, axis_if.tuser}, {hold_l, hold_u});
            end
            hold_v = axis_if.tvalid && !axis_if.tready;
            hold_d = axis_if.tdata;
            hold_k = axis_if.tkeep;
            hold_l = axis_if.tlast;
            hold_u = axis_if.tuser;
            if (axis_if.tvalid && axis_if.tready) begin
                chk("beat_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    for (int i = 0; i < c_OUT_BYTES; i++) mask[i*8 +: 8] = {8{e.k[i]}};
                    chk("tdata", axis_if.tdata & mask, e.d);
                    chk("tkeep", axis_if.tkeep, e.k);
                    chk("tlast", axis_if.tlast, e.l);
                    chk("tuser", axis_if.tuser, e.u);
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        axis_if.tready = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_tvalid", axis_if.tvalid, 1'b0);
        chk("rst_tdata", axis_if.tdata, '0);
        chk("rst_tkeep", axis_if.tkeep, '0);
        chk("rst_tlast", axis_if.tlast, 1'b0);
        chk("rst_tuser", axis_if.tuser, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // x4 8-bit: 16-byte packet over 4 cycles -> one beat
        cfg_lanes = 6'd4; cfg_width = 6'd8;
        build_pkt(16, 8'hFB, 8'hFD, 1);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_x4_8b");

        // Start symbol without K flag must be ignored
        build_pkt(4, 8'hFB, 8'h00, 9);
        pk[0] = 1'b0;
        drive_stream();

        // x4 32-bit: 80-byte packet -> full beat + 16-byte last beat
        cfg_width = 6'd32;
        build_pkt(80, 8'h5C, 8'hFD, 2);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_80b");

        // Start and ENDP in one cycle; trailing bytes discarded
        build_pkt(6, 8'h5C, 8'hFD, 3);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_short");

        // Lane reversal, x2 16-bit: SDP on physical lane 1
        cfg_rev = 1'b1; cfg_lanes = 6'd2; cfg_width = 6'd16;
        build_pkt(10, 8'h5C, 8'hFD, 4);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_reverse");
        cfg_rev = 1'b0; cfg_lanes = 6'd4; cfg_width = 6'd32;

        // EDB in second beat -> tlast+tuser on 6-byte tail
        build_pkt(70, 8'h5C, 8'hFE, 5);
        expect_pkt(1);
        drive_stream();
        wait_drain("drain_edb");

        // Link down after 12 bytes (x4 8-bit)
        cfg_width = 6'd8;
        build_pkt(12, 8'hFB, 8'h00, 6);
        expect_pkt(1);
        drive_stream();
        link_up = 1'b0;
        build_pkt(4, 8'h11, 8'h00, 7);
        drive_stream();
        link_up = 1'b1;
        build_pkt(8, 8'hFB, 8'hFD, 8);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_linkdown");

        // Backpressure: 5th beat overflows, rest of packet dropped
        cfg_width = 6'd32;
        axis_if.tready = 1'b0;
        ovf_cycles = 0;
        build_pkt(352, 8'h5C, 8'hFD, 10);
        expect_pkt(0);
        while (sb.size() > 4) void'(sb.pop_back());
        drive_stream();
        repeat (2) @(posedge clk_i);
        #1;
        chk("overflow_pulse_cycles", ovf_cycles, 1);
        chk("fifo_full_tvalid", axis_if.tvalid, 1'b1);
        axis_if.tready = 1'b1;
        wait_drain("drain_overflow_fifo");
        build_pkt(16, 8'h5C, 8'hFD, 11);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_after_overflow");

        // Reset mid-packet with a beat waiting in the FIFO
        axis_if.tready = 1'b0;
        build_pkt(80, 8'h5C, 8'h00, 12);
        drive_stream();
        chk("pre_reset_tvalid", axis_if.tvalid, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_reset_tvalid", axis_if.tvalid, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        axis_if.tready = 1'b1;
        build_pkt(80, 8'hFB, 8'hFD, 13);
        expect_pkt(0);
        drive_stream();
        wait_drain("drain_post_reset");

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
